// File: rtl/store_merge_ctrl_pkg.sv
// Shared encodings for the store merge controller: access sizes, FSM states
// and the alignment rule that decides whether a store is rejected.
package store_merge_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    // True for stores the memory path cannot perform: size 11, odd half, unaligned word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/store_merge_ctrl_lane.sv
// Little-endian lane insertion: drops right-aligned store data into the
// addressed byte/half lanes of an existing word, leaving other bytes intact.
module byte_lane_merge
    import store_merge_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    default: merged[31:24] = new_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) merged[31:16] = new_data[15:0];
                else        merged[15:0]  = new_data[15:0];
            end
            SZ_WORD: merged = new_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge_ctrl.sv
// Store path into a word-wide memory without byte enables: word stores write
// directly, byte/half stores read the word, merge the lanes and write it back.
module store_merge_ctrl
    import store_merge_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [31:0] merged;
    logic        accept;

    // Upper address bits are outside the memory and deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign accept = req_valid && req_ready;

    byte_lane_merge u_lane_merge (
        .old_word (mem_rdata),
        .new_data (wdata_q),
        .size     (size_q),
        .off      (off_q),
        .merged   (merged)
    );

    // Outputs are registered alongside the state so each one reflects the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            off_q     <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        off_q     <= req_addr[1:0];
                        size_q    <= req_size;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            state     <= WRITE;
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            mem_wr_en <= 1'b1;
                            mem_wdata <= req_wdata;
                            done      <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state <= MERGE;
                end
                MERGE: begin
                    // mem_rdata carries the word read in READ during this cycle.
                    state     <= WRITE;
                    mem_wr_en <= 1'b1;
                    mem_wdata <= merged;
                    done      <= 1'b1;
                end
                WRITE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
                ERR: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_ctrl.sv
// Bench for store_merge_ctrl: directed cases plus random stores checked
// against a word-array reference model and a synchronous-read memory.
module tb_store_merge_ctrl;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    store_merge_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data memory with no byte enables.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] old, input logic [1:0] off,
                                             input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        case (sz)
            2'd0:    begin sh = 8 * int'(off);     mask = 32'hFF   << sh; end
            2'd1:    begin sh = 16 * int'(off[1]); mask = 32'hFFFF << sh; end
            default: begin sh = 0;                 mask = 32'hFFFF_FFFF;  end
        endcase
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    function automatic logic is_bad(input logic [31:0] addr, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] status();
        return {27'd0, req_ready, mem_rd_en, mem_wr_en, done, err};
    endfunction

    // One request, sampled each cycle until the block is idle again.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz);
        logic        bad;
        logic [9:0]  idx;
        logic [31:0] expw;
        logic [4:0]  est;
        logic [31:0] eaddr;
        int          last;
        bad  = is_bad(addr, sz);
        idx  = addr[11:2];
        expw = ref_word(ref_mem[idx], addr[1:0], wd, sz);
        last = (bad || sz == 2'd2) ? 2 : 4;
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_wdata = wd; req_size = sz;
        check("ready_c0", {31'd0, req_ready}, 32'd1);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
                req_size = 2'($urandom);
            end
            eaddr = 32'(idx);
            if (c == last)           begin est = 5'b10000; eaddr = 0; end
            else if (bad)            begin est = 5'b00001; eaddr = 0; end
            else if (c == last - 1)  est = 5'b00110;
            else if (c == 1)         est = 5'b01000;
            else                     est = 5'b00000;
            check($sformatf("status_c%0d", c), status(), {27'd0, est});
            check($sformatf("addr_c%0d", c), {22'd0, mem_addr}, eaddr);
            if (est[2]) check("wdata", mem_wdata, expw);
        end
        if (!bad) ref_mem[idx] = expw;
    endtask

    initial begin
        int          wr_cnt;
        int          mism;
        logic [31:0] wd1;
        logic [31:0] wd2;
        logic [31:0] exp1;

        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[0] = 32'h1122_3344; ref_mem[0] = 32'h1122_3344;
        mem[1] = 32'hCAFE_F00D; ref_mem[1] = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        check("rst_status", status(), 32'b10000);
        check("rst_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_status", status(), 32'b10000);

        do_store(32'h0000_0008, 32'h1234_5678, 2'b10);
        check("plan_word", mem[2], 32'h1234_5678);
        do_store(32'h0000_0002, 32'h0000_00AB, 2'b00);
        check("plan_byte", mem[0], 32'h11AB_3344);
        do_store(32'h0000_0006, 32'h0000_BEEF, 2'b01);
        check("plan_half", mem[1], 32'hBEEF_F00D);
        do_store(32'h0000_0003, 32'h0000_5555, 2'b01);
        do_store(32'h0000_0002, 32'h7777_7777, 2'b10);
        do_store(32'h0000_0010, 32'h9999_9999, 2'b11);
        do_store(32'hFFFF_F00C, 32'h0BAD_CAFE, 2'b10);

        // Byte store followed by a word store held valid across the first.
        wd1 = $urandom; wd2 = $urandom;
        exp1 = ref_word(ref_mem[4], 2'd1, wd1, 2'd0);
        ref_mem[4] = exp1;
        ref_mem[8] = wd2;
        wr_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0011; req_wdata = wd1; req_size = 2'b00;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (mem_wr_en) wr_cnt++;
            if (c == 1) begin req_addr = 32'h0000_0020; req_wdata = wd2; req_size = 2'b10; end
            if (c == 3) begin
                check("b2b_st1", status(), 32'b00110);
                check("b2b_wd1", mem_wdata, exp1);
            end
            if (c == 4) check("b2b_ready", status(), 32'b10000);
            if (c == 5) begin
                check("b2b_st2", status(), 32'b00110);
                check("b2b_wd2", mem_wdata, wd2);
                check("b2b_addr2", {22'd0, mem_addr}, 32'd8);
                req_valid = 1'b0;
            end
        end
        check("b2b_wr_cnt", wr_cnt, 32'd2);

        // Reset during MERGE abandons the write.
        wr_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0031; req_wdata = 32'h0000_00EE; req_size = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_read", status(), 32'b01000);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rstmid_status", status(), 32'b10000);
        check("rstmid_addr", {22'd0, mem_addr}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (mem_wr_en) wr_cnt++;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (mem_wr_en) wr_cnt++;
        end
        check("rstmid_no_wr", wr_cnt, 32'd0);
        check("rstmid_ready", status(), 32'b10000);
        do_store(32'h0000_0031, 32'h0000_00EE, 2'b00);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = $urandom;
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'd3) s = 2'd0;
                if (s == 2'd2) a[1:0] = 2'd0;
                if (s == 2'd1) a[0] = 1'b0;
            end
            do_store(a, $urandom, s);
        end

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("mem_final", mism, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_merge_ctrl.md
Name: store_merge_ctrl

Overview:
- Store-side counterpart of the immediate/load extender: narrows a byte/half/word store into a full 32-bit memory word.
- Sits between the datapath store port and a word-wide data memory that has no byte enables.
- Word stores write directly. Sub-word stores do read-modify-write over a synchronous-read memory, under a valid/ready request handshake and a done/err completion pulse.

Parameters:
- ADDR_W, 10, word-address width of the data memory (1024 words); mem_addr = req_addr[ADDR_W+1:2].

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  store request present
- req_ready  output  1  block can accept a request
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- mem_addr  output  ADDR_W  word address to data memory
- mem_rd_en  output  1  read strobe; mem_rdata is valid the following cycle
- mem_rdata  input  32  memory read data
- mem_wr_en  output  1  write strobe, one cycle
- mem_wdata  output  32  full word to write
- done  output  1  one-cycle pulse when the store is written
- err  output  1  one-cycle pulse on a rejected misaligned or illegal request

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n: asynchronous assert, active-low.
- Reset values: state IDLE; req_ready 1; all other outputs 0; internal latches 0.
- Handshake:
  - Accept occurs when req_valid && req_ready.
  - req_ready is 1 only in IDLE.
  - On accept, latch addr, wdata and size.
  - Request inputs are don't-care outside the accept cycle.
- Outputs are Moore, decoded from state plus latched registers.
- State IDLE:
  - On accept with a misaligned or illegal request, go to ERR. Misaligned/illegal means: half with addr[0]=1; word with addr[1:0]!=0; or size 11.
  - On accept of a valid word store, go to WRITE.
  - On accept of a valid byte or half store, go to READ.
  - Otherwise stay in IDLE.
- State READ: mem_rd_en=1, mem_addr=latched word index; next state MERGE.
- State MERGE:
  - Capture mem_rdata and replace the selected lanes into the merge register; next state WRITE.
  - Memory strobes are 0 in this state.
- State WRITE: mem_wr_en=1, mem_wdata=merge register (word store: latched wdata), mem_addr=word index, done=1; next state IDLE.
- State ERR: err=1; no memory strobe; next state IDLE.
- Lane mapping (little-endian):
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: addr[1]=0 → bits[15:0], addr[1]=1 → bits[31:16], gets wdata[15:0].
  - Unselected bytes are kept unchanged from mem_rdata.
- Latency, counting the accept cycle as c0:
  - word: mem_wr_en and done at c1.
  - sub-word: mem_rd_en at c1, merge at c2, mem_wr_en and done at c3.
  - err: err at c1.
- Back-to-back: the next accept is possible in the cycle after WRITE/ERR (req_ready returns with IDLE). There is no overlap.
- mem_addr holds the latched word index in READ/MERGE/WRITE and is 0 in IDLE/ERR.
- Reset mid-operation: immediate return to reset values. A pending write is abandoned and mem_wr_en is never asserted for it.
- Address bits above ADDR_W+1 are ignored (no range error).

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding IDLE/READ/MERGE/WRITE/ERR (3 bits);
  - misalignment check function.
- One combinational sub-module, byte_lane_merge, with inputs old_word[31:0], new_data[31:0], size[1:0], off[1:0] and output merged[31:0]. It is reusable by a later load-align unit's inverse test.
- The FSM and registers stay in store_merge_ctrl.

Test Plan:
- Word store: addr 0x00000008, wdata 0x12345678, size 10 → c1: mem_wr_en=1, mem_addr=2, mem_wdata=0x12345678, done=1; mem_rd_en never asserted.
- Byte store: mem[0]=0x11223344, addr 0x2, wdata 0x000000AB, size 00 → c1 mem_rd_en with mem_addr=0; c3 mem_wdata=0x11AB3344, done=1.
- Half store upper: mem[1]=0xCAFEF00D, addr 0x6, wdata 0x0000BEEF, size 01 → c3 mem_wdata=0xBEEFF00D at mem_addr=1.
- Misaligned and illegal requests:
  - half at addr 0x3 → c1 err=1, no mem strobes, req_ready=1 at c2.
  - word at 0x2 → same response.
  - size 11 → same response.
- Back-to-back: byte store then word store held valid → second accept in the cycle after the first done; exactly two mem_wr_en pulses.
- Reset mid-op: reset_n low during MERGE of a byte store → outputs zero immediately, no mem_wr_en; after release req_ready=1 and the next store completes normally.
